// File: rtl/funcq_stream.sv
// Streaming evaluator of q = ((a-b)*(1+3*c) - 4*d)/2 on signed operands.
// Four-stage stallable pipeline with ready/valid handshakes, selectable rounding/saturation and an overflow event counter.
module funcq_stream #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter int SATURATE   = 1,
  parameter int ROUND_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   a,
  input  logic [IN_W-1:0]   b,
  input  logic [IN_W-1:0]   c,
  input  logic [IN_W-1:0]   d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  q,
  output logic              ovf,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  ovf_cnt
);

  localparam int D_W = IN_W + 1;
  localparam int T_W = IN_W + 2;
  localparam int P_W = 2 * IN_W + 3;
  localparam int S_W = 2 * IN_W + 4;

  localparam logic signed [T_W-1:0] ONE_T   = {{(T_W-1){1'b0}}, 1'b1};
  localparam logic [OUT_W-1:0]      Q_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      Q_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // stage valids and data registers
  logic                    v1_r, v2_r, v3_r, v4_r;
  logic signed [D_W-1:0]   diff_r;
  logic signed [T_W-1:0]   t_r;
  logic [IN_W-1:0]         d1_r, d2_r;
  logic signed [P_W-1:0]   prod_r;
  logic signed [S_W-1:0]   s_r;
  logic [OUT_W-1:0]        q_r;
  logic                    ovf_r;
  logic [CNT_W-1:0]        ovf_cnt_r;

  // combinational stage results
  logic                    en1_s, en2_s, en3_s, en4_s;
  logic signed [D_W-1:0]   diff_s;
  logic signed [T_W-1:0]   c_ext_s, t_s;
  logic signed [P_W-1:0]   diff_x_s, t_x_s, prod_s;
  logic signed [S_W-1:0]   prod_x_s, d4_s, s_s;
  logic                    adj_s;
  logic signed [S_W-1:0]   sum_s, r_s;
  logic [S_W-OUT_W:0]      upper_s;
  logic                    ovf_s;
  logic [OUT_W-1:0]        q_s;

  // Enable chain: a stage may load when it is empty or its successor moves.
  always_comb begin
    en4_s = ~v4_r | out_ready;
    en3_s = ~v3_r | en4_s;
    en2_s = ~v2_r | en3_s;
    en1_s = ~v1_r | en2_s;
  end

  assign in_ready  = en1_s;
  assign out_valid = v4_r;
  assign q         = q_r;
  assign ovf       = ovf_r;
  assign ovf_cnt   = ovf_cnt_r;

  // Datapath arithmetic for every stage, all widths sized to be exact.
  always_comb begin
    diff_s   = {a[IN_W-1], a} - {b[IN_W-1], b};
    c_ext_s  = {{2{c[IN_W-1]}}, c};
    t_s      = c_ext_s + (c_ext_s <<< 1'b1) + ONE_T;

    diff_x_s = {{(P_W-D_W){diff_r[D_W-1]}}, diff_r};
    t_x_s    = {{(P_W-T_W){t_r[T_W-1]}}, t_r};
    prod_s   = diff_x_s * t_x_s;

    prod_x_s = {prod_r[P_W-1], prod_r};
    d4_s     = {{(S_W-IN_W-2){d2_r[IN_W-1]}}, d2_r, 2'b00};
    s_s      = prod_x_s - d4_s;

    // Round toward zero only differs from floor for negative odd values.
    if (ROUND_MODE == 1) begin
      adj_s = s_r[S_W-1] & s_r[0];
    end else begin
      adj_s = 1'b0;
    end
    sum_s   = s_r + $signed({{(S_W-1){1'b0}}, adj_s});
    r_s     = sum_s >>> 1'b1;
    upper_s = r_s[S_W-1:OUT_W-1];
    ovf_s   = ~((&upper_s) | ~(|upper_s));

    if (ovf_s && (SATURATE != 0)) begin
      q_s = r_s[S_W-1] ? Q_MIN : Q_MAX;
    end else begin
      q_s = r_s[OUT_W-1:0];
    end
  end

  // Pipeline registers; data only moves with a valid set to keep bubbles quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r   <= 1'b0;
      v2_r   <= 1'b0;
      v3_r   <= 1'b0;
      v4_r   <= 1'b0;
      diff_r <= '0;
      t_r    <= '0;
      d1_r   <= '0;
      d2_r   <= '0;
      prod_r <= '0;
      s_r    <= '0;
      q_r    <= '0;
      ovf_r  <= 1'b0;
    end else begin
      if (en1_s) begin
        v1_r <= in_valid;
        if (in_valid) begin
          diff_r <= diff_s;
          t_r    <= t_s;
          d1_r   <= d;
        end
      end
      if (en2_s) begin
        v2_r <= v1_r;
        if (v1_r) begin
          prod_r <= prod_s;
          d2_r   <= d1_r;
        end
      end
      if (en3_s) begin
        v3_r <= v2_r;
        if (v2_r) begin
          s_r <= s_s;
        end
      end
      if (en4_s) begin
        v4_r <= v3_r;
        if (v3_r) begin
          q_r   <= q_s;
          ovf_r <= ovf_s;
        end
      end
    end
  end

  // Overflow event counter: saturates, and a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_r <= '0;
    end else if (cnt_clr) begin
      ovf_cnt_r <= '0;
    end else if (v4_r && out_ready && ovf_r && (ovf_cnt_r != CNT_MAX)) begin
      ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_funcq_stream.sv
// Scoreboard bench for funcq_stream: one instance floor/saturate, one round-to-zero/wrap,
// both fed the same stream and checked against an integer reference model.
module tb_funcq_stream;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [W-1:0]  a = '0, b = '0, c = '0, d = '0;

  logic          in_ready0, out_valid0, ovf0;
  logic          in_ready1, out_valid1, ovf1;
  logic [W-1:0]  q0, q1, cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [16:0]   sbq0[$];
  logic [16:0]   sbq1[$];
  logic [15:0]   exp_cnt0 = '0;
  logic [15:0]   exp_cnt1 = '0;

  funcq_stream #(.IN_W(W), .OUT_W(W), .SATURATE(1), .ROUND_MODE(0), .CNT_W(W)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid0), .out_ready(out_ready), .q(q0), .ovf(ovf0),
    .cnt_clr(cnt_clr), .ovf_cnt(cnt0)
  );

  funcq_stream #(.IN_W(W), .OUT_W(W), .SATURATE(0), .ROUND_MODE(1), .CNT_W(W)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .c(c), .d(d),
    .out_valid(out_valid1), .out_ready(out_ready), .q(q1), .ovf(ovf1),
    .cnt_clr(cnt_clr), .ovf_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // returns {ovf, q}
  function automatic logic [16:0] model(input logic signed [15:0] av, bv, cv, dv,
                                        input bit rm, input bit sat);
    longint s, r;
    logic [15:0] qv;
    logic o;
    s = (longint'(av) - longint'(bv)) * (64'sd1 + 64'sd3 * longint'(cv)) - 64'sd4 * longint'(dv);
    if (rm && (s < 64'sd0) && ((s & 64'sd1) != 64'sd0)) s = s + 64'sd1;
    r = s >>> 1;
    o = (r > 64'sd32767) || (r < -64'sd32768);
    if (o && sat) qv = (r < 64'sd0) ? 16'h8000 : 16'h7FFF;
    else          qv = 16'(r);
    return {o, qv};
  endfunction

  // One clock: drive at negedge, sample 1 unit later, score both instances.
  task automatic cycle(input bit iv, input logic [15:0] av, bv, cv, dv, input bit ordy, input bit clr);
    @(negedge clk);
    in_valid = iv; a = av; b = bv; c = cv; d = dv;
    out_ready = ordy; cnt_clr = clr;
    #1;
    check("cnt0", cnt0, exp_cnt0);
    if (out_valid0) begin
      if (sbq0.size() == 0) check("spurious0", out_valid0, 1'b0);
      else begin
        check("q0", q0, sbq0[0][15:0]);
        check("ovf0", ovf0, sbq0[0][16]);
        if (ordy) begin
          if (sbq0[0][16] && exp_cnt0 != 16'hFFFF) exp_cnt0 = exp_cnt0 + 16'd1;
          void'(sbq0.pop_front());
        end
      end
    end
    if (clr) exp_cnt0 = 16'd0;
    if (iv && in_ready0) sbq0.push_back(model(av, bv, cv, dv, 1'b0, 1'b1));

    check("cnt1", cnt1, exp_cnt1);
    if (out_valid1) begin
      if (sbq1.size() == 0) check("spurious1", out_valid1, 1'b0);
      else begin
        check("q1", q1, sbq1[0][15:0]);
        check("ovf1", ovf1, sbq1[0][16]);
        if (ordy) begin
          if (sbq1[0][16] && exp_cnt1 != 16'hFFFF) exp_cnt1 = exp_cnt1 + 16'd1;
          void'(sbq1.pop_front());
        end
      end
    end
    if (clr) exp_cnt1 = 16'd0;
    if (iv && in_ready1) sbq1.push_back(model(av, bv, cv, dv, 1'b1, 1'b0));
  endtask

  // Single set through an empty pipe: latency plus hand-computed expectations.
  task automatic run_one(input logic [15:0] av, bv, cv, dv,
                         input logic [15:0] eq0, eq1, input logic eovf, input string tag);
    int lat;
    cycle(1'b1, av, bv, cv, dv, 1'b1, 1'b0);
    lat = 0;
    do begin
      cycle(1'b0, av, bv, cv, dv, 1'b1, 1'b0);
      lat++;
    end while (!out_valid0 && lat < 10);
    check({tag, "_lat"}, lat, 64'd4);
    check({tag, "_ov1"}, out_valid1, 1'b1);
    check({tag, "_q0"}, q0, eq0);
    check({tag, "_q1"}, q1, eq1);
    check({tag, "_ovf0"}, ovf0, eovf);
    check({tag, "_ovf1"}, ovf1, eovf);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 50) begin
      cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
      n++;
    end
    check({tag, "_drain"}, sbq0.size() + sbq1.size(), 64'd0);
  endtask

  function automatic logic [15:0] rnd_op();
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    else                           return 16'(int'($urandom_range(0, 40)) - 20);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end

  initial begin
    int idx, n_out, gaps, acc, cyc;
    bit iv;

    // reset state
    #12;
    check("rst_ov0", out_valid0, 1'b0);
    check("rst_q0", q0, 16'd0);
    check("rst_ovf0", ovf0, 1'b0);
    check("rst_cnt0", cnt0, 16'd0);
    check("rst_ov1", out_valid1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_irdy", in_ready0, 1'b1);

    // basic, rounding, overflow
    run_one(16'd5, 16'd2, 16'd1, 16'd1, 16'd4, 16'd4, 1'b0, "t1");
    run_one(16'd0, 16'd1, 16'd0, 16'd0, 16'hFFFF, 16'h0000, 1'b0, "t2");
    run_one(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h4001, 1'b1, "t3");
    cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    check("t3_cnt0", cnt0, 16'd1);
    check("t3_cnt1", cnt1, 16'd1);

    // backpressure: 10 sets offered back to back, consumer stalled 8 cycles
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 16'(idx * 977), 16'(-idx * 313), 16'(idx * 41), 16'(idx * 7), 1'b0, 1'b0);
      if (in_ready0) idx++;
    end
    check("t4_acc", idx, 64'd4);
    check("t4_irdy", in_ready0, 1'b0);
    n_out = 0;
    gaps = 0;
    for (int k = 0; k < 20; k++) begin
      iv = (idx < 10);
      cycle(iv, 16'(idx * 977), 16'(-idx * 313), 16'(idx * 41), 16'(idx * 7), 1'b1, 1'b0);
      if (iv && in_ready0) idx++;
      if (out_valid0) n_out++;
      else if (n_out < 10) gaps++;
    end
    check("t4_nout", n_out, 64'd10);
    check("t4_gaps", gaps, 64'd0);
    drain("t4");

    // random valid/ready toggling
    acc = 0;
    cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      iv = ($urandom_range(0, 3) != 0);
      cycle(iv, rnd_op(), rnd_op(), rnd_op(), rnd_op(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
      if (iv && in_ready0) acc++;
      cyc++;
    end
    check("t5_acc", acc, 64'd10000);
    drain("t5");

    // mid-stream reset with 3 sets in flight
    run_one(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h4001, 1'b1, "t6a");
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 16'(k + 3), 16'd1, 16'd2, 16'd1, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("t6_pre_ov", out_valid0, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_ov0", out_valid0, 1'b0);
    check("t6_ov1", out_valid1, 1'b0);
    check("t6_cnt0", cnt0, 16'd0);
    check("t6_cnt1", cnt1, 16'd0);
    sbq0.delete();
    sbq1.delete();
    exp_cnt0 = 16'd0;
    exp_cnt1 = 16'd0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_one(16'd5, 16'd2, 16'd1, 16'd1, 16'd4, 16'd4, 1'b0, "t6b");

    // counter clear coincident with an overflowed handshake
    run_one(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h4001, 1'b1, "t6c");
    cycle(1'b1, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0);
    cyc = 0;
    do begin
      cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
      cyc++;
    end while (!out_valid0 && cyc < 10);
    check("t6_cnt_pre", cnt0, 16'd1);
    check("t6_held_ovf", ovf0, 1'b1);
    cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b1);
    cycle(1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
    check("t6_clr0", cnt0, 16'd0);
    check("t6_clr1", cnt1, 16'd0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
